resource_share_arbiter: RTL and testbench

Shares one fixed-latency pipelined resource (divider, memory port, multiplier) among NUM_REQ HLS-generated FSMs. It arbitrates issue slots round-robin, routes each result back to its issuer, and drives each FSM's `fsm_stall` so the FSM holds its issuing state until its own result returns. It sits between the per-function FSMs and the resource instance.

---
 rtl/resource_share_arbiter_pkg.sv | 23 ++
 rtl/resource_share_arbiter_rr_arbiter.sv | 34 +++
 rtl/resource_share_arbiter.sv | 113 +++++++++++
 tb/tb_resource_share_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/resource_share_arbiter_pkg.sv
// Shared types for the resource-share arbiter: requester state encoding,
// issue-tag layout and the requester-id width helper.
package share_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PEND   = 2'd1,
      ST_FLIGHT = 2'd2
   } req_state_e;

   // Up to 16 requesters, so four id bits always suffice in the tag.
   localparam int MAX_ID_W = 4;

   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic                valid;
      logic [MAX_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/resource_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first eligible requester at or
// after rr_ptr_i, at most one grant, and none while enable_i is low.
module rr_arbiter
   import share_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]           eligible_i,
   input  logic                         enable_i,
   input  logic [id_width(NUM_REQ)-1:0] rr_ptr_i,
   output logic [NUM_REQ-1:0]           grant_o,
   output logic [id_width(NUM_REQ)-1:0] grant_id_o,
   output logic                         any_grant_o
);

   localparam int ID_W = id_width(NUM_REQ);

   always_comb begin
      logic [ID_W-1:0] idx;
      grant_o     = '0;
      grant_id_o  = '0;
      any_grant_o = 1'b0;
      idx         = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = ID_W'((int'(rr_ptr_i) + off) % NUM_REQ);
         if (enable_i && !any_grant_o && eligible_i[idx]) begin
            grant_o[idx] = 1'b1;
            grant_id_o   = idx;
            any_grant_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/resource_share_arbiter.sv
// Shares one fixed-latency pipelined resource among NUM_REQ FSMs: round-robin
// issue, tag pipeline to route each result back, and per-FSM stall.
module resource_share_arbiter
   import share_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int LAT     = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_op_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_op_b,
   output logic [NUM_REQ-1:0]        fsm_stall,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   input  logic                      res_ready,
   output logic                      res_issue,
   output logic [DATA_W-1:0]         res_op_a,
   output logic [DATA_W-1:0]         res_op_b,
   input  logic [DATA_W-1:0]         res_result
);

   localparam int ID_W = id_width(NUM_REQ);

   req_state_e         state_q [NUM_REQ];
   logic [ID_W-1:0]    rr_ptr_q;
   logic [ID_W-1:0]    rr_ptr_d;
   tag_t               tag_q [LAT];
   tag_t               tag_d;
   tag_t               tag_last;
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_id;
   logic               any_grant;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         // Ops already in flight are masked so a held request is not reissued.
         assign eligible[gi]  = req_valid[gi] && (state_q[gi] != ST_FLIGHT);
         assign rsp_valid[gi] = reset && tag_last.valid && (tag_last.id == MAX_ID_W'(gi));
      end
   endgenerate

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .eligible_i  (eligible),
      .enable_i    (res_ready & reset),
      .rr_ptr_i    (rr_ptr_q),
      .grant_o     (grant),
      .grant_id_o  (grant_id),
      .any_grant_o (any_grant)
   );

   assign res_issue = any_grant;

   always_comb begin
      res_op_a = '0;
      res_op_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            res_op_a = req_op_a[i*DATA_W +: DATA_W];
            res_op_b = req_op_b[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (any_grant) begin
         rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
   end

   assign tag_d.valid = any_grant;
   assign tag_d.id    = MAX_ID_W'(grant_id);
   assign tag_last    = tag_q[LAT-1];

   assign rsp_data  = (reset && tag_last.valid) ? res_result : '0;
   assign fsm_stall = reset ? (req_valid & ~rsp_valid) : '0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         rr_ptr_q <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            state_q[i] <= ST_IDLE;
         end
         for (int k = 0; k < LAT; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         rr_ptr_q <= rr_ptr_d;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (rsp_valid[i]) begin
               state_q[i] <= ST_IDLE;
            end else if (grant[i]) begin
               state_q[i] <= ST_FLIGHT;
            end else if (state_q[i] != ST_FLIGHT) begin
               state_q[i] <= req_valid[i] ? ST_PEND : ST_IDLE;
            end
         end
         // The tag line advances every cycle, independent of res_ready.
         tag_q[0] <= tag_d;
         for (int k = 1; k < LAT; k++) begin
            tag_q[k] <= tag_q[k-1];
         end
      end
   end

endmodule

// File: tb/tb_resource_share_arbiter.sv
// Scoreboard bench for resource_share_arbiter with a multiplier resource model
// and requester models that hold req_valid until their response returns.
module tb_resource_share_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 32;
   localparam int LAT     = 3;

   logic                      clk = 1'b0;
   logic                      reset = 1'b0;
   logic [NUM_REQ-1:0]        req_valid = '0;
   logic [NUM_REQ*DATA_W-1:0] req_op_a = '0;
   logic [NUM_REQ*DATA_W-1:0] req_op_b = '0;
   logic [NUM_REQ-1:0]        fsm_stall;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;
   logic                      res_ready = 1'b1;
   logic                      res_issue;
   logic [DATA_W-1:0]         res_op_a;
   logic [DATA_W-1:0]         res_op_b;
   logic [DATA_W-1:0]         res_result;

   resource_share_arbiter #(
      .NUM_REQ (NUM_REQ),
      .DATA_W  (DATA_W),
      .LAT     (LAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_op_a   (req_op_a),
      .req_op_b   (req_op_b),
      .fsm_stall  (fsm_stall),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .res_ready  (res_ready),
      .res_issue  (res_issue),
      .res_op_a   (res_op_a),
      .res_op_b   (res_op_b),
      .res_result (res_result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Resource model: product appears LAT cycles after issue, junk otherwise.
   logic [DATA_W-1:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= res_issue ? res_op_a * res_op_b : (32'hDEAD_BEEF ^ DATA_W'(cyc));
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign res_result = pipe[LAT-1];

   typedef struct {
      int                id;
      logic [DATA_W-1:0] data;
      int                due;
   } exp_t;

   exp_t sb [$];
   int   n_checks = 0;
   int   n_err = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   logic [DATA_W-1:0]  my_a [NUM_REQ];
   logic [DATA_W-1:0]  my_b [NUM_REQ];
   int                 remaining [NUM_REQ];
   logic [NUM_REQ-1:0] rsp_seen = '0;
   logic [NUM_REQ-1:0] outstanding = '0;
   int                 pend_ready [NUM_REQ];
   int                 issue_hist [NUM_REQ][$];
   int                 rsp_hist [NUM_REQ][$];
   int                 seq = 0;
   bit                 starve_mode = 1'b0;
   int                 last_id = -1;

   initial begin
      for (int i = 0; i < NUM_REQ; i++) begin
         my_a[i] = '0;
         my_b[i] = '0;
         remaining[i] = 0;
         pend_ready[i] = 0;
      end
   end

   task automatic new_ops(input int i);
      seq++;
      my_a[i] = {8'(i), 24'(seq)};
      my_b[i] = DATA_W'($urandom_range(1, 65535));
      req_op_a[i*DATA_W +: DATA_W] = my_a[i];
      req_op_b[i*DATA_W +: DATA_W] = my_b[i];
   endtask

   // Requester models: keep req_valid up until the response, then either
   // start the next op in the following cycle or drop the request.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (rsp_seen[i]) begin
               rsp_seen[i] = 1'b0;
               if (remaining[i] > 0) remaining[i]--;
               if (remaining[i] > 0) new_ops(i);
               req_valid[i] = (remaining[i] > 0);
            end else if (!req_valid[i] && remaining[i] > 0) begin
               new_ops(i);
               req_valid[i] = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [NUM_REQ-1:0] exp_rsp;
      logic [NUM_REQ-1:0] elig;
      logic [DATA_W-1:0]  prod;
      int                 id;
      bit                 src_ok;
      exp_rsp = '0;
      id = -1;
      if (!reset) begin
         check_val("rst_rsp_valid", rsp_valid, 0);
         check_val("rst_res_issue", res_issue, 0);
         check_val("rst_stall", fsm_stall, 0);
         sb.delete();
         outstanding = '0;
         for (int i = 0; i < NUM_REQ; i++) pend_ready[i] = 0;
      end else begin
         if (sb.size() > 0 && sb[0].due == cyc) exp_rsp[sb[0].id] = 1'b1;
         check_val("rsp_valid", rsp_valid, exp_rsp);
         check_val("stall", fsm_stall, req_valid & ~exp_rsp);
         if (exp_rsp != 0) check_val("rsp_data", rsp_data, sb[0].data);
         else              check_val("rsp_idle_data", rsp_data, 0);

         elig = req_valid & ~outstanding;
         check_val("issue", res_issue, res_ready && (elig != 0));
         if (res_issue) begin
            id = int'(res_op_a[DATA_W-1 -: 8]);
            src_ok = (id >= 0 && id < NUM_REQ) ? elig[id] : 1'b0;
            check_val("issue_src", src_ok, 1);
            if (src_ok) begin
               check_val("issue_op_a", res_op_a, my_a[id]);
               check_val("issue_op_b", res_op_b, my_b[id]);
               check_val("fair_wait", pend_ready[id] <= NUM_REQ - 1, 1);
               if (starve_mode) begin
                  check_val("starve_wait", pend_ready[id] <= 1, 1);
                  if (last_id >= 0) check_val("starve_alt", id != last_id, 1);
                  last_id = id;
               end
               prod = my_a[id] * my_b[id];
               sb.push_back('{id, prod, cyc + LAT});
               outstanding[id] = 1'b1;
               issue_hist[id].push_back(cyc);
               $display("issue  cyc=%0d req=%0d a=%0h b=%0h", cyc, id, res_op_a, res_op_b);
            end
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (elig[i] && res_ready) begin
               if (i == id) pend_ready[i] = 0;
               else         pend_ready[i]++;
            end
         end

         if (exp_rsp != 0) begin
            outstanding[sb[0].id] = 1'b0;
            void'(sb.pop_front());
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (rsp_valid[i]) begin
               rsp_seen[i] = 1'b1;
               rsp_hist[i].push_back(cyc);
               $display("rsp    cyc=%0d req=%0d data=%0h", cyc, i, rsp_data);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_hist();
      for (int i = 0; i < NUM_REQ; i++) begin
         issue_hist[i].delete();
         rsp_hist[i].delete();
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req_valid = '0;
      rsp_seen = '0;
      for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;
      tick(2);
      reset = 1'b1;
      clear_hist();
   endtask

   task automatic start(input int i, input int n);
      remaining[i] = n;
   endtask

   task automatic exp_issue(input string tag, input int i, input int k, input int c);
      if (issue_hist[i].size() > k) check_val(tag, issue_hist[i][k], c);
      else                          check_val(tag, 64'hFFFF_FFFF, c);
   endtask

   task automatic exp_rsp_at(input string tag, input int i, input int k, input int c);
      if (rsp_hist[i].size() > k) check_val(tag, rsp_hist[i][k], c);
      else                        check_val(tag, 64'hFFFF_FFFF, c);
   endtask

   initial begin
      int c;
      int left;
      do_reset();

      // Single requester
      tick(10);
      c = cyc;
      start(0, 1);
      tick(6);
      exp_issue("single_issue", 0, 0, c);
      exp_rsp_at("single_rsp", 0, 0, c + 3);
      check_val("single_count", issue_hist[0].size(), 1);

      // All four at once, then pointer wraps back to 0
      do_reset();
      c = cyc;
      for (int i = 0; i < NUM_REQ; i++) start(i, 1);
      tick(10);
      for (int i = 0; i < NUM_REQ; i++) begin
         exp_issue("all4_issue", i, 0, c + i);
         exp_rsp_at("all4_rsp", i, 0, c + i + 3);
      end
      clear_hist();
      c = cyc;
      start(3, 1);
      start(0, 1);
      tick(6);
      exp_issue("ptr_wrap_0", 0, 0, c);
      exp_issue("ptr_wrap_3", 3, 0, c + 1);

      // res_ready held low with requester 2 pending
      do_reset();
      res_ready = 1'b0;
      c = cyc;
      start(2, 1);
      tick(5);
      res_ready = 1'b1;
      tick(6);
      exp_issue("ready_issue", 2, 0, c + 5);
      exp_rsp_at("ready_rsp", 2, 0, c + 8);

      // Back-to-back ops on requester 1
      do_reset();
      c = cyc;
      start(1, 2);
      tick(10);
      check_val("b2b_count", issue_hist[1].size(), 2);
      exp_issue("b2b_issue0", 1, 0, c);
      exp_issue("b2b_issue1", 1, 1, c + 4);
      exp_rsp_at("b2b_rsp0", 1, 0, c + 3);
      exp_rsp_at("b2b_rsp1", 1, 1, c + 7);

      // Reset with two ops in flight
      do_reset();
      c = cyc;
      start(0, 1);
      start(1, 1);
      tick(2);
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      req_valid = '0;
      rsp_seen = '0;
      for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;
      clear_hist();
      tick(2);
      check_val("stale_rsp", rsp_hist[0].size() + rsp_hist[1].size(), 0);
      start(1, 1);
      start(2, 1);
      tick(8);
      exp_issue("post_rst_issue1", 1, 0, c + 6);
      exp_rsp_at("post_rst_rsp1", 1, 0, c + 9);
      exp_issue("post_rst_issue2", 2, 0, c + 7);
      check_val("stale_rsp0", rsp_hist[0].size(), 0);

      // Two continuous requesters must alternate
      do_reset();
      starve_mode = 1'b1;
      last_id = -1;
      start(0, 10);
      start(3, 10);
      tick(48);
      starve_mode = 1'b0;
      check_val("starve_n0", issue_hist[0].size(), 10);
      check_val("starve_n3", issue_hist[3].size(), 10);

      // Random res_ready with all requesters busy
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) start(i, 3);
      for (int k = 0; k < 40; k++) begin
         res_ready = 1'($urandom_range(0, 1));
         tick(1);
      end
      res_ready = 1'b1;
      tick(60);
      left = 0;
      for (int i = 0; i < NUM_REQ; i++) left += remaining[i];
      check_val("rand_done", left, 0);

      check_val("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
